// File: rtl/ffstdp_pkg.sv
// Shared constants and helpers for the forward-forward STDP update engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ffstdp_pkg;

    // Derivative LUT polarity encoding, used for both write select and read select.
    localparam logic LUT_POS = 1'b1;
    localparam logic LUT_NEG = 1'b0;

    // Entries per derivative table.
    function automatic int lut_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Width of the unsigned deriv * pre product.
    function automatic int product_width(input int deriv_width, input int pre_act_width);
        return deriv_width + pre_act_width;
    endfunction

    // Largest representable signed weight.
    function automatic int w_max(input int weight_width);
        return (1 << (weight_width - 1)) - 1;
    endfunction

    // Smallest representable signed weight.
    function automatic int w_min(input int weight_width);
        return -(1 << (weight_width - 1));
    endfunction

endpackage

// File: rtl/ffstdp_deriv_lut.sv
// Dual derivative tables (pos/neg) as a register file: synchronous write, async read.
// Latency: read is combinational; a write is visible after its clock edge (same-cycle read sees old data).
// Backpressure: none; writes are always accepted.
// Ports: clk/rst, write port (we, wr_sel, waddr, wdata), read port (rd_sel, raddr -> rdata).
module ffstdp_deriv_lut
    import ffstdp_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  wr_sel,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_sel,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = lut_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] pos_mem [DEPTH];
    logic [DATA_WIDTH-1:0] neg_mem [DEPTH];

    // Cleared tables make every update a no-op until software programs them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pos_mem[i] <= '0;
                neg_mem[i] <= '0;
            end
        end else if (we) begin
            case (wr_sel)
                LUT_POS: pos_mem[waddr] <= wdata;
                LUT_NEG: neg_mem[waddr] <= wdata;
            endcase
        end
    end

    assign rdata = (rd_sel == LUT_POS) ? pos_mem[raddr] : neg_mem[raddr];

endmodule

// File: rtl/ffstdp_update_pipe.sv
// Forward-forward STDP weight update: LUT derivative * pre count, LR shift, saturating add to weight.
// Latency: 3 cycles (S1 LUT read, S2 multiply, S3 shift/sign/saturate), one update per cycle.
// Backpressure: whole pipe stalls as one unit when OUT_VALID && !OUT_READY; IN_READY = advance.
// Ports: CFG_* program LUTs and LR shift; IN_* / OUT_* valid-ready streams with pass-through
//        synapse address; UPD_CNT counts accepted training results; BUSY = any stage valid.
module ffstdp_update_pipe
    import ffstdp_pkg::*;
#(
    parameter int PRE_CNT_WIDTH  = 8,
    parameter int POST_CNT_WIDTH = 7,
    parameter int PRE_ACT_WIDTH  = 5,
    parameter int LUT_ADDR_WIDTH = 5,
    parameter int DERIV_WIDTH    = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int SYN_ADDR_WIDTH = 16,
    parameter int LR_SHIFT_WIDTH = 3,
    parameter int UPD_CNT_WIDTH  = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CFG_LUT_WE,
    input  logic                      CFG_LUT_SEL,
    input  logic [LUT_ADDR_WIDTH-1:0] CFG_LUT_ADDR,
    input  logic [DERIV_WIDTH-1:0]    CFG_LUT_WDATA,
    input  logic [LR_SHIFT_WIDTH-1:0] CFG_LR_SHIFT,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      IN_IS_POS,
    input  logic                      IN_IS_TRAIN,
    input  logic [SYN_ADDR_WIDTH-1:0] IN_SYN_ADDR,
    input  logic [PRE_CNT_WIDTH-1:0]  IN_PRE_CNT,
    input  logic [POST_CNT_WIDTH-1:0] IN_POST_CNT,
    input  logic [WEIGHT_WIDTH-1:0]   IN_WSYN,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [SYN_ADDR_WIDTH-1:0] OUT_SYN_ADDR,
    output logic [WEIGHT_WIDTH-1:0]   OUT_WSYN,
    output logic                      OUT_SAT,
    output logic [UPD_CNT_WIDTH-1:0]  UPD_CNT,
    output logic                      BUSY
);

    localparam int PRODUCT_WIDTH = product_width(DERIV_WIDTH, PRE_ACT_WIDTH);

    localparam logic [WEIGHT_WIDTH-1:0]   W_MAX_V     = WEIGHT_WIDTH'(w_max(WEIGHT_WIDTH));
    localparam logic [WEIGHT_WIDTH-1:0]   W_MIN_V     = WEIGHT_WIDTH'(w_min(WEIGHT_WIDTH));
    localparam logic [PRODUCT_WIDTH-1:0]  MAG_CAP     = PRODUCT_WIDTH'(w_max(WEIGHT_WIDTH));
    localparam logic [PRE_CNT_WIDTH-1:0]  PRE_CAP     = PRE_CNT_WIDTH'((1 << PRE_ACT_WIDTH) - 1);
    localparam logic [PRE_ACT_WIDTH-1:0]  PRE_ACT_MAX = '1;
    localparam logic [POST_CNT_WIDTH-1:0] POST_CAP    = POST_CNT_WIDTH'(lut_depth(LUT_ADDR_WIDTH) - 1);
    localparam logic [LUT_ADDR_WIDTH-1:0] LUT_IDX_MAX = '1;

    logic advance;

    // S1 (LUT read) inputs
    logic [LUT_ADDR_WIDTH-1:0] post_idx;
    logic [PRE_ACT_WIDTH-1:0]  pre_act;
    logic [DERIV_WIDTH-1:0]    lut_rdata;

    // Stage registers
    logic                      s1_vld, s1_pos, s1_train;
    logic [SYN_ADDR_WIDTH-1:0] s1_addr;
    logic [WEIGHT_WIDTH-1:0]   s1_wsyn;
    logic [DERIV_WIDTH-1:0]    s1_deriv;
    logic [PRE_ACT_WIDTH-1:0]  s1_pre;

    logic                      s2_vld, s2_pos, s2_train;
    logic [SYN_ADDR_WIDTH-1:0] s2_addr;
    logic [WEIGHT_WIDTH-1:0]   s2_wsyn;
    logic [PRODUCT_WIDTH-1:0]  s2_product;
    logic [LR_SHIFT_WIDTH-1:0] s2_lr;

    logic                      s3_train;

    // S3 combinational result
    logic [PRODUCT_WIDTH-1:0]  mag_full;
    logic [WEIGHT_WIDTH-1:0]   mag;
    logic [WEIGHT_WIDTH:0]     sum;
    logic [WEIGHT_WIDTH-1:0]   wsyn_nxt;
    logic                      sat_nxt;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;
    assign BUSY     = s1_vld || s2_vld || OUT_VALID;

    // Out-of-range counts clamp to the top entry rather than aliasing via truncation.
    assign post_idx = (IN_POST_CNT > POST_CAP) ? LUT_IDX_MAX : IN_POST_CNT[LUT_ADDR_WIDTH-1:0];
    assign pre_act  = (IN_PRE_CNT > PRE_CAP) ? PRE_ACT_MAX : IN_PRE_CNT[PRE_ACT_WIDTH-1:0];

    ffstdp_deriv_lut #(
        .ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH (DERIV_WIDTH)
    ) u_lut (
        .clk    (CLK),
        .rst    (RST),
        .we     (CFG_LUT_WE),
        .wr_sel (CFG_LUT_SEL),
        .waddr  (CFG_LUT_ADDR),
        .wdata  (CFG_LUT_WDATA),
        .rd_sel (IN_IS_POS),
        .raddr  (post_idx),
        .rdata  (lut_rdata)
    );

    // The fixed PRE_ACT_WIDTH shift normalises the pre-count scale; lr adds on top.
    always_comb begin
        mag_full = s2_product >> (PRE_ACT_WIDTH + int'(s2_lr));
        mag      = (mag_full > MAG_CAP) ? MAG_CAP[WEIGHT_WIDTH-1:0] : mag_full[WEIGHT_WIDTH-1:0];
        sum      = s2_pos ? ({s2_wsyn[WEIGHT_WIDTH-1], s2_wsyn} + {1'b0, mag})
                          : ({s2_wsyn[WEIGHT_WIDTH-1], s2_wsyn} - {1'b0, mag});
        wsyn_nxt = sum[WEIGHT_WIDTH-1:0];
        sat_nxt  = 1'b0;
        if (!s2_train) begin
            wsyn_nxt = s2_wsyn;
        end else if (sum[WEIGHT_WIDTH] != sum[WEIGHT_WIDTH-1]) begin
            // Sum exceeds the weight range; the extra sign bit tells which end.
            wsyn_nxt = sum[WEIGHT_WIDTH] ? W_MIN_V : W_MAX_V;
            sat_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld       <= 1'b0;
            s1_pos       <= 1'b0;
            s1_train     <= 1'b0;
            s1_addr      <= '0;
            s1_wsyn      <= '0;
            s1_deriv     <= '0;
            s1_pre       <= '0;
            s2_vld       <= 1'b0;
            s2_pos       <= 1'b0;
            s2_train     <= 1'b0;
            s2_addr      <= '0;
            s2_wsyn      <= '0;
            s2_product   <= '0;
            s2_lr        <= '0;
            s3_train     <= 1'b0;
            OUT_VALID    <= 1'b0;
            OUT_SYN_ADDR <= '0;
            OUT_WSYN     <= '0;
            OUT_SAT      <= 1'b0;
            UPD_CNT      <= '0;
        end else begin
            if (advance) begin
                s1_vld       <= IN_VALID;
                s1_pos       <= IN_IS_POS;
                s1_train     <= IN_IS_TRAIN;
                s1_addr      <= IN_SYN_ADDR;
                s1_wsyn      <= IN_WSYN;
                s1_deriv     <= lut_rdata;
                s1_pre       <= pre_act;

                s2_vld       <= s1_vld;
                s2_pos       <= s1_pos;
                s2_train     <= s1_train;
                s2_addr      <= s1_addr;
                s2_wsyn      <= s1_wsyn;
                s2_product   <= PRODUCT_WIDTH'(s1_deriv) * PRODUCT_WIDTH'(s1_pre);
                s2_lr        <= CFG_LR_SHIFT;

                s3_train     <= s2_train;
                OUT_VALID    <= s2_vld;
                OUT_SYN_ADDR <= s2_addr;
                OUT_WSYN     <= wsyn_nxt;
                OUT_SAT      <= sat_nxt;
            end
            // Zero-delta training results still count as applied updates.
            if (OUT_VALID && OUT_READY && s3_train) begin
                UPD_CNT <= UPD_CNT + UPD_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ffstdp_update_pipe.sv
module tb_ffstdp_update_pipe;
    import ffstdp_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CFG_LUT_WE = 1'b0;
    logic        CFG_LUT_SEL = 1'b0;
    logic [4:0]  CFG_LUT_ADDR = '0;
    logic [7:0]  CFG_LUT_WDATA = '0;
    logic [2:0]  CFG_LR_SHIFT = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        IN_IS_POS = 1'b0;
    logic        IN_IS_TRAIN = 1'b0;
    logic [15:0] IN_SYN_ADDR = '0;
    logic [7:0]  IN_PRE_CNT = '0;
    logic [6:0]  IN_POST_CNT = '0;
    logic [7:0]  IN_WSYN = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [15:0] OUT_SYN_ADDR;
    logic [7:0]  OUT_WSYN;
    logic        OUT_SAT;
    logic [15:0] UPD_CNT;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    ffstdp_update_pipe dut (
        .CLK           (CLK),
        .RST           (RST),
        .CFG_LUT_WE    (CFG_LUT_WE),
        .CFG_LUT_SEL   (CFG_LUT_SEL),
        .CFG_LUT_ADDR  (CFG_LUT_ADDR),
        .CFG_LUT_WDATA (CFG_LUT_WDATA),
        .CFG_LR_SHIFT  (CFG_LR_SHIFT),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .IN_IS_POS     (IN_IS_POS),
        .IN_IS_TRAIN   (IN_IS_TRAIN),
        .IN_SYN_ADDR   (IN_SYN_ADDR),
        .IN_PRE_CNT    (IN_PRE_CNT),
        .IN_POST_CNT   (IN_POST_CNT),
        .IN_WSYN       (IN_WSYN),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_SYN_ADDR  (OUT_SYN_ADDR),
        .OUT_WSYN      (OUT_WSYN),
        .OUT_SAT       (OUT_SAT),
        .UPD_CNT       (UPD_CNT),
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lut_wr(input logic sel, input logic [4:0] addr, input logic [7:0] data);
        CFG_LUT_WE    = 1'b1;
        CFG_LUT_SEL   = sel;
        CFG_LUT_ADDR  = addr;
        CFG_LUT_WDATA = data;
        tick();
        CFG_LUT_WE    = 1'b0;
    endtask

    task automatic drive(input logic pos, input logic train, input logic [15:0] addr,
                         input logic [7:0] pre, input logic [6:0] post, input logic [7:0] w);
        IN_VALID    = 1'b1;
        IN_IS_POS   = pos;
        IN_IS_TRAIN = train;
        IN_SYN_ADDR = addr;
        IN_PRE_CNT  = pre;
        IN_POST_CNT = post;
        IN_WSYN     = w;
    endtask

    // One isolated transaction: accept, wait 3 cycles, check result, then check the counter.
    task automatic run_one(input string tag, input logic pos, input logic train, input logic [15:0] addr,
                           input logic [7:0] pre, input logic [6:0] post, input logic [7:0] w,
                           input int exp_w, input int exp_sat, input int exp_upd);
        drive(pos, train, addr, pre, post, w);
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        chk({tag, "_valid"}, OUT_VALID, 1);
        chk({tag, "_wsyn"}, 32'($signed(OUT_WSYN)), exp_w);
        chk({tag, "_sat"}, OUT_SAT, exp_sat);
        chk({tag, "_addr"}, OUT_SYN_ADDR, addr);
        tick();
        chk({tag, "_upd"}, UPD_CNT, exp_upd);
    endtask

    initial begin
        int sent, recv, cyc, n_stall, n_out;
        logic was_stall;
        logic [7:0]  hold_w;
        logic [15:0] hold_a;

        // Reset state
        tick();
        tick();
        RST = 1'b0;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_wsyn", OUT_WSYN, 0);
        chk("rst_out_addr", OUT_SYN_ADDR, 0);
        chk("rst_out_sat", OUT_SAT, 0);
        chk("rst_upd", UPD_CNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_in_ready", IN_READY, 1);

        // Positive update with latency detail: 64*10 >> 5 = 20, 10 + 20 = 30
        lut_wr(LUT_POS, 5'd3, 8'd64);
        drive(1'b1, 1'b1, 16'h0011, 8'd10, 7'd3, 8'd10);
        tick();
        IN_VALID = 1'b0;
        chk("pos_lat1_valid", OUT_VALID, 0);
        chk("pos_lat1_busy", BUSY, 1);
        tick();
        chk("pos_lat2_valid", OUT_VALID, 0);
        tick();
        chk("pos_valid", OUT_VALID, 1);
        chk("pos_wsyn", 32'($signed(OUT_WSYN)), 30);
        chk("pos_sat", OUT_SAT, 0);
        chk("pos_addr", OUT_SYN_ADDR, 16'h0011);
        chk("pos_upd_before", UPD_CNT, 0);
        tick();
        chk("pos_upd", UPD_CNT, 1);
        chk("pos_drained", OUT_VALID, 0);
        chk("pos_idle", BUSY, 0);

        // Negative saturation: 255*31 = 7905 >> 5 = 247 -> 127; -120 - 127 = -247 -> -128
        lut_wr(LUT_NEG, 5'd3, 8'd255);
        run_one("neg_sat", 1'b0, 1'b1, 16'h0022, 8'd31, 7'd3, 8'(-120), -128, 1, 2);

        // Clamped indices + shift 2: LUT[31]=32, pre 31, 992 >> 7 = 7
        lut_wr(LUT_POS, 5'd31, 8'd32);
        CFG_LR_SHIFT = 3'd2;
        run_one("clamp_shift", 1'b1, 1'b1, 16'h0033, 8'd200, 7'd100, 8'd0, 7, 0, 3);
        CFG_LR_SHIFT = 3'd0;

        // Non-training pass-through even though the LUT entry is large
        run_one("nontrain", 1'b0, 1'b0, 16'h0044, 8'd31, 7'd3, 8'(-5), -5, 0, 3);

        // Backpressure: 6 back-to-back inputs, OUT_READY low in cycles 4..7.
        // POS_LUT[3]=64 so delta = 2*pre; item i (1..6): pre=i, w=10i -> 12i.
        sent = 0; recv = 0; cyc = 0; n_stall = 0; was_stall = 1'b0;
        hold_w = '0; hold_a = '0;
        while (recv < 6 && cyc < 60) begin
            OUT_READY = !(cyc >= 4 && cyc <= 7);
            if (sent < 6) drive(1'b1, 1'b1, 16'(256 + sent + 1), 8'(sent + 1), 7'd3, 8'(10 * (sent + 1)));
            else IN_VALID = 1'b0;
            #1;
            if (was_stall) begin
                chk("bp_hold_wsyn", OUT_WSYN, hold_w);
                chk("bp_hold_addr", OUT_SYN_ADDR, hold_a);
            end
            if (OUT_VALID && !OUT_READY) begin
                chk("bp_in_ready_low", IN_READY, 0);
                hold_w = OUT_WSYN;
                hold_a = OUT_SYN_ADDR;
                was_stall = 1'b1;
                n_stall++;
            end else begin
                was_stall = 1'b0;
            end
            if (OUT_VALID && OUT_READY) begin
                chk("bp_wsyn", 32'($signed(OUT_WSYN)), 12 * (recv + 1));
                chk("bp_addr", OUT_SYN_ADDR, 256 + recv + 1);
                recv++;
            end
            if (IN_VALID && IN_READY) sent++;
            @(posedge CLK);
            #1;
            cyc++;
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        chk("bp_recv_count", recv, 6);
        chk("bp_stall_cycles", n_stall, 4);
        chk("bp_upd", UPD_CNT, 9);

        // Reset with 3 transactions in flight
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 16'(16'h0070 + k), 8'd20, 7'd3, 8'd50);
            tick();
        end
        IN_VALID = 1'b0;
        chk("mid_busy", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_upd", UPD_CNT, 0);
        chk("mid_rst_wsyn", OUT_WSYN, 0);
        n_out = 0;
        for (int k = 0; k < 5; k++) begin
            if (OUT_VALID) n_out++;
            tick();
        end
        chk("mid_rst_no_out", n_out, 0);
        // LUT was cleared: weight passes unchanged but still counts as an update
        run_one("post_rst_lut", 1'b1, 1'b1, 16'h0055, 8'd10, 7'd3, 8'd10, 10, 0, 1);

        // LUT write collides with S1 read of entry 5: old 32 -> 31, new 96 -> 93
        lut_wr(LUT_POS, 5'd5, 8'd32);
        drive(1'b1, 1'b1, 16'h0066, 8'd31, 7'd5, 8'd0);
        CFG_LUT_WE    = 1'b1;
        CFG_LUT_SEL   = LUT_POS;
        CFG_LUT_ADDR  = 5'd5;
        CFG_LUT_WDATA = 8'd96;
        tick();
        CFG_LUT_WE  = 1'b0;
        IN_SYN_ADDR = 16'h0067;
        tick();
        IN_VALID = 1'b0;
        tick();
        chk("coll_old_valid", OUT_VALID, 1);
        chk("coll_old_wsyn", 32'($signed(OUT_WSYN)), 31);
        chk("coll_old_addr", OUT_SYN_ADDR, 16'h0066);
        tick();
        chk("coll_new_valid", OUT_VALID, 1);
        chk("coll_new_wsyn", 32'($signed(OUT_WSYN)), 93);
        chk("coll_new_addr", OUT_SYN_ADDR, 16'h0067);
        tick();
        chk("coll_upd", UPD_CNT, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
